// File: rtl/bbpll_lock_detector.sv
// ============================================================================
// Module      : bbpll_lock_detector
// Description : Lock detector for a bang-bang PLL. Declares lock after two
//               consecutive windows of phase decisions with no over-long run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbpll_lock_detector #(
    parameter int NUM_LOCK_WINDOW_BITS = 7,
    parameter int NUM_RUN_COUNTER_BITS = 4
) (
    input  logic       referenceClock,
    input  logic       reset,
    input  logic       enable,
    input  logic       pdValid,
    input  logic       pdEarly,
    input  logic [2:0] lockThreshold,
    output logic       locked,
    output logic       lockLost,
    output logic [1:0] cleanWindows
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACQUIRE = 2'd1;
    localparam logic [1:0] c_LOCKED  = 2'd2;

    localparam int c_CMP_W = (NUM_RUN_COUNTER_BITS > 4) ? NUM_RUN_COUNTER_BITS : 4;

    localparam logic [NUM_RUN_COUNTER_BITS-1:0] c_RUN_SAT  = '1;
    localparam logic [NUM_LOCK_WINDOW_BITS-1:0] c_WIN_LAST = '1;

    logic [1:0]                      r_state;
    logic [NUM_LOCK_WINDOW_BITS-1:0] r_windowCount;
    logic [NUM_RUN_COUNTER_BITS-1:0] r_runCount;
    logic                            r_lastDecision;
    logic                            r_violation;
    logic [3:0]                      r_maxRun;
    logic [1:0]                      r_cleanWindows;
    logic                            r_locked;
    logic                            r_lockLost;

    logic                            w_windowStart;
    logic                            w_windowEnd;
    logic [3:0]                      w_maxRun;
    logic [NUM_RUN_COUNTER_BITS-1:0] w_nextRun;
    logic                            w_violationNow;
    logic                            w_dirty;

    // The limit for the first sample of a window is taken straight from the
    // input so that sample is judged against the newly latched threshold.
    assign w_windowStart  = (r_windowCount == '0);
    assign w_windowEnd    = (r_windowCount == c_WIN_LAST);
    assign w_maxRun       = w_windowStart ? ({1'b0, lockThreshold} + 4'd1) : r_maxRun;
    assign w_nextRun      = (pdEarly != r_lastDecision) ? NUM_RUN_COUNTER_BITS'(1) :
                            (r_runCount == c_RUN_SAT)   ? r_runCount :
                                                          r_runCount + NUM_RUN_COUNTER_BITS'(1);
    assign w_violationNow = (c_CMP_W'(w_nextRun) > c_CMP_W'(w_maxRun));
    assign w_dirty        = r_violation | w_violationNow;

    always_ff @(posedge referenceClock or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_windowCount  <= '0;
            r_runCount     <= '0;
            r_lastDecision <= 1'b0;
            r_violation    <= 1'b0;
            r_maxRun       <= 4'd0;
            r_cleanWindows <= 2'd0;
            r_locked       <= 1'b0;
            r_lockLost     <= 1'b0;
        end else begin
            r_lockLost <= 1'b0;
            if (!enable) begin
                r_state        <= c_IDLE;
                r_windowCount  <= '0;
                r_runCount     <= '0;
                r_lastDecision <= 1'b0;
                r_violation    <= 1'b0;
                r_cleanWindows <= 2'd0;
                r_locked       <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state        <= c_ACQUIRE;
                        r_windowCount  <= '0;
                        r_runCount     <= '0;
                        r_lastDecision <= 1'b0;
                        r_violation    <= 1'b0;
                        r_cleanWindows <= 2'd0;
                        r_locked       <= 1'b0;
                    end
                    c_ACQUIRE, c_LOCKED: begin
                        if (pdValid) begin
                            r_runCount     <= w_nextRun;
                            r_lastDecision <= pdEarly;
                            r_windowCount  <= r_windowCount + NUM_LOCK_WINDOW_BITS'(1);
                            if (w_windowStart) begin
                                r_maxRun <= w_maxRun;
                            end
                            if (w_windowEnd) begin
                                r_violation <= 1'b0;
                                if (w_dirty) begin
                                    r_cleanWindows <= 2'd0;
                                    if (r_state == c_LOCKED) begin
                                        r_state    <= c_ACQUIRE;
                                        r_locked   <= 1'b0;
                                        r_lockLost <= 1'b1;
                                    end
                                end else if (r_state == c_ACQUIRE) begin
                                    if (r_cleanWindows != 2'd0) begin
                                        r_cleanWindows <= 2'd2;
                                        r_state        <= c_LOCKED;
                                        r_locked       <= 1'b1;
                                    end else begin
                                        r_cleanWindows <= 2'd1;
                                    end
                                end
                            end else if (w_violationNow) begin
                                r_violation <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= c_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked       = r_locked;
    assign lockLost     = r_lockLost;
    assign cleanWindows = r_cleanWindows;

endmodule

`default_nettype wire

// File: tb/tb_bbpll_lock_detector.sv
// ============================================================================
// Module      : tb_bbpll_lock_detector
// Description : Directed-plus-random bench against a sample-indexed model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bbpll_lock_detector;

    localparam int WIN = 128;
    localparam int SAT = 15;

    logic       referenceClock = 1'b0;
    logic       reset;
    logic       enable;
    logic       pdValid;
    logic       pdEarly;
    logic [2:0] lockThreshold;
    logic       locked;
    logic       lockLost;
    logic [1:0] cleanWindows;

    bbpll_lock_detector #(
        .NUM_LOCK_WINDOW_BITS(7),
        .NUM_RUN_COUNTER_BITS(4)
    ) dut (
        .referenceClock(referenceClock),
        .reset(reset),
        .enable(enable),
        .pdValid(pdValid),
        .pdEarly(pdEarly),
        .lockThreshold(lockThreshold),
        .locked(locked),
        .lockLost(lockLost),
        .cleanWindows(cleanWindows)
    );

    always #5 referenceClock = ~referenceClock;

    int errs   = 0;
    int checks = 0;

    // Model: 0 idle, 1 acquiring, 2 locked; samples indexed from acquisition start
    int mState, mSamples, mTrail, mLast, mDirty, mClean, mMax, mLost;
    bit dec;
    int blk;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0; mSamples = 0; mTrail = 0; mLast = 0;
        mDirty = 0; mClean = 0; mMax = 1; mLost = 0;
    endtask

    task automatic modelStep(input bit en, input bit v, input bit e, input int thr);
        int pos;
        mLost = 0;
        if (!en) begin
            mState = 0;
            mClean = 0;
        end else if (mState == 0) begin
            mState = 1; mSamples = 0; mTrail = 0; mLast = 0; mDirty = 0; mClean = 0;
        end else if (v) begin
            pos = mSamples % WIN;
            if (pos == 0) mMax = thr + 1;
            mTrail = (mTrail > 0 && int'(e) == mLast) ? mTrail + 1 : 1;
            mLast  = int'(e);
            if (((mTrail < SAT) ? mTrail : SAT) > mMax) mDirty = 1;
            mSamples++;
            if (pos == WIN - 1) begin
                if (mDirty != 0) begin
                    if (mState == 2) mLost = 1;
                    mState = 1;
                    mClean = 0;
                end else begin
                    mClean = (mClean < 2) ? mClean + 1 : 2;
                    if (mClean == 2) mState = 2;
                end
                mDirty = 0;
            end
        end
    endtask

    task automatic step(input bit en, input bit v, input bit e, input int thr);
        @(negedge referenceClock);
        enable        = en;
        pdValid       = v;
        pdEarly       = e;
        lockThreshold = 3'(thr);
        @(posedge referenceClock);
        #1;
        modelStep(en, v, e, thr);
        checkVal("locked", int'(locked), (mState == 2) ? 1 : 0);
        checkVal("lockLost", int'(lockLost), mLost);
        checkVal("cleanWindows", int'(cleanWindows), mClean);
    endtask

    // One valid decision, toggling after runLen identical decisions
    task automatic pushSample(input int thr, input int runLen);
        if (blk >= runLen) begin
            dec = ~dec;
            blk = 0;
        end
        blk++;
        step(1'b1, 1'b1, dec, thr);
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        blk = 0;
    endtask

    task automatic doReset();
        @(negedge referenceClock);
        #1 reset = 1'b1;
        #1;
        checkVal("rstLocked", int'(locked), 0);
        checkVal("rstLockLost", int'(lockLost), 0);
        checkVal("rstClean", int'(cleanWindows), 0);
        modelReset();
        @(negedge referenceClock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pdValid = 1'b0; pdEarly = 1'b0; lockThreshold = 3'd0;
        modelReset();
        dec = 1'($urandom);
        blk = 0;
        repeat (3) @(posedge referenceClock);
        #1;
        checkVal("initLocked", int'(locked), 0);
        checkVal("initLockLost", int'(lockLost), 0);
        checkVal("initClean", int'(cleanWindows), 0);
        @(negedge referenceClock);
        reset = 1'b0;

        // Alternating decisions at the tightest threshold
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 300; i++) pushSample(0, 1);

        // Runs of five: always dirty at threshold 3, clean at threshold 4
        restart();
        for (int i = 0; i < 1024; i++) pushSample(3, 5);
        restart();
        for (int i = 0; i < 300; i++) pushSample(4, 5);

        // Lock, then one run of nine mid-window, then relock
        restart();
        for (int i = 0; i < 260; i++) pushSample(1, 1);
        while ((mSamples % WIN) != 40) pushSample(1, 1);
        dec = ~dec;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, dec, 1);
        blk = 1;
        for (int i = 0; i < 400; i++) pushSample(1, 1);

        // Threshold drop mid-window with runs of three
        restart();
        while ((mSamples % WIN) != 60) pushSample(7, 3);
        for (int i = 0; i < 300; i++) pushSample(0, 3);

        // Sparse strobes; decision input toggles randomly on idle cycles
        restart();
        for (int i = 0; i < 800; i++) begin
            if ((i % 3) == 2) pushSample(0, 1);
            else step(1'b1, 1'b0, 1'($urandom), 0);
        end

        // Reset mid-acquisition, relock, then drop enable with a strobe present
        restart();
        for (int i = 0; i < 200; i++) pushSample(2, 1);
        doReset();
        step(1'b1, 1'b0, 1'b0, 2);
        blk = 0;
        for (int i = 0; i < 260; i++) pushSample(2, 1);
        step(1'b0, 1'b1, ~dec, 2);
        step(1'b0, 1'b1, dec, 2);
        step(1'b1, 1'b0, 1'b0, 2);

        // Randomized traffic
        begin
            int thr;
            int runLen;
            thr    = 3;
            runLen = 1;
            for (int i = 0; i < 5000; i++) begin
                if (($urandom % 400) == 0) thr = 1 + int'($urandom % 7);
                if (($urandom % 900) == 0) begin
                    step(1'b0, 1'($urandom), 1'($urandom), thr);
                end else if (($urandom % 4) == 0) begin
                    step(1'b1, 1'b0, 1'($urandom), thr);
                end else begin
                    if (blk >= runLen) begin
                        runLen = (($urandom % 150) == 0) ? 10 : 1 + int'($urandom % 3);
                    end
                    pushSample(thr, runLen);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
